sobel_sched: RTL and testbench

Job scheduler for the `sobel_filter` HLS component. Takes a job of the form (base index, count) and issues one component call per index `base .. base+count-1`, honouring the component's call/return stall handshake. Collects the returned results in order into an internal FIFO, presents them on a valid/ready result stream, and signals job completion. The block sits between the host-side control logic and one `sobel_filter` instance.

---
 rtl/sobel_sched_pkg.sv | 14 +
 rtl/sobel_sched_fifo.sv | 51 +++++
 rtl/sobel_sched.sv | 128 ++++++++++++
 tb/tb_sobel_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_sched_pkg.sv
// Shared types and default widths for the sobel_filter job scheduler.
package sobel_sched_pkg;

  localparam int DEF_IDX_W  = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sobel_sched_fifo.sv
// Synchronous result FIFO (non fall-through).
// The read data is forced to zero while the FIFO is empty.
module sobel_sched_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/sobel_sched.sv
// Issues one sobel_filter call per index of a (base, count) job and streams the
// in-order results out, with credit-based flow control so returns never stall.
module sobel_sched
  import sobel_sched_pkg::*;
#(
  parameter int IDX_W        = DEF_IDX_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_INFLIGHT = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [IDX_W-1:0]  cfg_base,
  input  logic [IDX_W-1:0]  cfg_count,
  output logic              cfg_busy,
  output logic              job_done,
  output logic              err_unexpected,
  output logic              comp_start,
  input  logic              comp_busy,
  output logic [IDX_W-1:0]  comp_idx,
  input  logic              comp_done,
  output logic              comp_stall,
  input  logic [DATA_W-1:0] comp_returndata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last
);

  localparam int IFW = $clog2(MAX_INFLIGHT) + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW  = ((IFW > FCW) ? IFW : FCW) + 1;

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_issue_cnt;
  logic [IDX_W-1:0] r_ret_cnt;
  logic [IFW-1:0]   r_inflight;
  logic             r_err;
  logic             w_full;
  logic             w_empty;
  logic [FCW-1:0]   w_fcount;
  logic [DATA_W:0]  w_rd;
  logic             w_credit;
  logic             w_accept;
  logic             w_ret;
  logic             w_pop;
  logic             w_last_push;
  logic             w_launch;

  // Every issued call reserves a FIFO slot, so a return always has room.
  assign w_credit    = (r_inflight < IFW'(MAX_INFLIGHT)) &&
                       ((SW'(r_inflight) + SW'(w_fcount)) < SW'(FIFO_DEPTH));
  assign comp_start  = (r_state == ISSUE) && w_credit;
  assign w_accept    = comp_start & ~comp_busy;
  // Stall only matters while a return can still arrive.
  assign comp_stall  = w_full & (r_inflight != '0);
  assign w_ret       = comp_done & ~comp_stall & (r_inflight != '0);
  assign w_last_push = (r_ret_cnt == IDX_W'(1));
  assign w_pop       = res_valid & res_ready;
  assign w_launch    = (r_state == IDLE) & cfg_start;

  assign comp_idx       = r_idx;
  assign cfg_busy       = (r_state != IDLE);
  assign job_done       = (r_state == DONE);
  assign err_unexpected = r_err;
  assign res_valid      = ~w_empty;
  assign res_data       = w_rd[DATA_W-1:0];
  assign res_last       = w_rd[DATA_W];

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cfg_start) w_state_nxt = (cfg_count != '0) ? ISSUE : DONE;
      ISSUE:   if (w_accept && (r_issue_cnt == IDX_W'(1))) w_state_nxt = DRAIN;
      DRAIN:   if (w_pop && res_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx       <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_inflight  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_launch) begin
        r_idx       <= cfg_base;
        r_issue_cnt <= cfg_count;
        r_ret_cnt   <= cfg_count;
      end else begin
        if (w_accept) begin
          r_idx       <= r_idx + IDX_W'(1);
          r_issue_cnt <= r_issue_cnt - IDX_W'(1);
        end
        if (w_ret) r_ret_cnt <= r_ret_cnt - IDX_W'(1);
      end
      r_inflight <= r_inflight + IFW'(w_accept) - IFW'(w_ret);
      if (comp_done && (r_inflight == '0)) r_err <= 1'b1;
    end
  end

  sobel_sched_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_ret),
    .i_wdata ({w_last_push, comp_returndata}),
    .i_pop   (w_pop),
    .o_rdata (w_rd),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fcount)
  );

endmodule

// File: tb/tb_sobel_sched.sv
// Bench for sobel_sched: behavioural component model, job-level scoreboard and
// directed jobs covering basic issue, zero count, credits, busy, wrap and reset.
module tb_sobel_sched;
  import sobel_sched_pkg::*;

  localparam int IDX_W        = 32;
  localparam int DATA_W       = 32;
  localparam int MAX_INFLIGHT = 8;
  localparam int FIFO_DEPTH   = 8;
  localparam int LAT          = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_start = 1'b0;
  logic [IDX_W-1:0]  cfg_base = '0;
  logic [IDX_W-1:0]  cfg_count = '0;
  logic              cfg_busy;
  logic              job_done;
  logic              err_unexpected;
  logic              comp_start;
  logic              comp_busy;
  logic [IDX_W-1:0]  comp_idx;
  logic              comp_done;
  logic              comp_stall;
  logic [DATA_W-1:0] comp_returndata;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [DATA_W-1:0] res_data;
  logic              res_last;

  sobel_sched #(
    .IDX_W(IDX_W), .DATA_W(DATA_W), .MAX_INFLIGHT(MAX_INFLIGHT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_count(cfg_count),
    .cfg_busy(cfg_busy), .job_done(job_done), .err_unexpected(err_unexpected),
    .comp_start(comp_start), .comp_busy(comp_busy), .comp_idx(comp_idx),
    .comp_done(comp_done), .comp_stall(comp_stall), .comp_returndata(comp_returndata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] ret_val(input logic [IDX_W-1:0] idx);
    return idx * 32'd3 + 32'd7;
  endfunction

  // ---------------- component model ----------------
  logic [IDX_W-1:0] pend_idx[$];
  int               pend_due[$];
  logic             busy_mode = 1'b0;
  logic [31:0]      busy_pat = 32'hB53C_96E1;
  int               bp = 0;
  int               stray_cnt = 0;
  int               stray_seen = 0;

  initial begin : comp_model
    logic stray_now;
    stray_now       = 1'b0;
    comp_done       = 1'b0;
    comp_busy       = 1'b0;
    comp_returndata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend_idx.delete();
        pend_due.delete();
      end else begin
        if (comp_done && !comp_stall && !stray_now && pend_idx.size() > 0) begin
          void'(pend_idx.pop_front());
          void'(pend_due.pop_front());
        end
        if (comp_start && !comp_busy) begin
          pend_idx.push_back(comp_idx);
          pend_due.push_back(cyc + LAT);
        end
      end
      @(posedge clock);
      #2;
      comp_done       = 1'b0;
      comp_returndata = '0;
      stray_now       = 1'b0;
      comp_busy       = busy_mode ? busy_pat[bp % 32] : 1'b0;
      bp++;
      if (stray_cnt != stray_seen) begin
        stray_seen++;
        stray_now       = 1'b1;
        comp_done       = 1'b1;
        comp_returndata = 32'hDEAD_BEEF;
      end else if (pend_idx.size() > 0 && pend_due[0] <= cyc) begin
        comp_done       = 1'b1;
        comp_returndata = ret_val(pend_idx[0]);
      end
    end
  end

  // ---------------- scoreboard / job model ----------------
  logic [DATA_W:0]  exp_q[$];
  logic [IDX_W-1:0] exp_idx_q[$];
  logic             m_busy = 1'b0;
  logic             m_done_now = 1'b0;
  logic             m_err = 1'b0;
  int               acc_cnt = 0;
  int               done_cnt = 0;
  int               start_cnt = 0;
  int               pop_cnt = 0;
  int               last_cnt = 0;

  initial begin : scoreboard
    logic [DATA_W:0]  e;
    logic [IDX_W-1:0] idx;
    logic             nb, nd, held_v;
    logic [IDX_W-1:0] held_idx;
    int               m_out;
    held_v = 1'b0; held_idx = '0; m_out = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        exp_idx_q.delete();
        m_busy = 1'b0; m_done_now = 1'b0; m_err = 1'b0;
        held_v = 1'b0; m_out = 0;
        continue;
      end
      check("busy", cfg_busy, m_busy);
      check("job_done", job_done, m_done_now);
      check("stall", comp_stall, 0);
      check("err", err_unexpected, m_err);
      if (!m_busy) check("start_idle", comp_start, 0);
      if (held_v) begin
        check("hold_start", comp_start, 1);
        check("hold_idx", comp_idx, held_idx);
      end
      held_v   = comp_start & comp_busy;
      held_idx = comp_idx;
      nb = m_busy;
      nd = 1'b0;
      if (comp_start) start_cnt++;
      if (job_done) done_cnt++;
      if (comp_start && !comp_busy) begin
        acc_cnt++;
        if (exp_idx_q.size() > 0) check("idx", comp_idx, exp_idx_q.pop_front());
        else check("call_extra", comp_start, 0);
      end
      if (comp_done) begin
        if (m_out == 0) m_err = 1'b1;
        else if (!comp_stall) m_out--;
      end
      if (comp_start && !comp_busy) m_out++;
      if (res_valid && res_ready) begin
        pop_cnt++;
        if (res_last) last_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("result", {res_last, res_data}, e);
          if (e[DATA_W]) nd = 1'b1;
        end else check("res_extra", res_valid, 0);
      end
      if (m_done_now) nb = 1'b0;
      if (cfg_start && !m_busy) begin
        nb = 1'b1;
        for (int unsigned i = 0; i < cfg_count; i++) begin
          idx = cfg_base + i;
          exp_idx_q.push_back(idx);
          exp_q.push_back({(i == cfg_count - 1), ret_val(idx)});
        end
        if (cfg_count == '0) nd = 1'b1;
      end
      m_busy     = nb;
      m_done_now = nd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [IDX_W-1:0] b, input logic [IDX_W-1:0] c);
    @(posedge clock); #1;
    cfg_start = 1'b1; cfg_base = b; cfg_count = c;
    @(posedge clock); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int  k;
    logic idle;
    k = 0;
    idle = 1'b0;
    while (!idle && k < limit) begin
      @(negedge clock); #1;
      k++;
      idle = !m_busy && exp_q.size() == 0 && exp_idx_q.size() == 0;
    end
    check(name, idle, 1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : main
    int a0, d0, s0, p0, l0, k;
    logic [IDX_W-1:0] wexp[3];

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock); #1;
    check("rst_busy", cfg_busy, 0);
    check("rst_done", job_done, 0);
    check("rst_start", comp_start, 0);
    check("rst_stall", comp_stall, 0);
    check("rst_valid", res_valid, 0);
    check("rst_last", res_last, 0);
    check("rst_err", err_unexpected, 0);
    check("rst_idx", comp_idx, 0);
    check("rst_data", res_data, 0);

    // Basic job: base 10, count 4.
    d0 = done_cnt; p0 = pop_cnt; l0 = last_cnt;
    start_job(32'd10, 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      check("basic_start", comp_start, 1);
      check("basic_idx", comp_idx, 10 + i);
    end
    wait_idle("basic_idle", 60);
    check("basic_pops", pop_cnt - p0, 4);
    check("basic_lasts", last_cnt - l0, 1);
    check("basic_done_pulses", done_cnt - d0, 1);

    // Zero count.
    s0 = start_cnt; d0 = done_cnt;
    start_job(32'd77, 32'd0);
    @(negedge clock); #1;
    check("zero_done", job_done, 1);
    check("zero_busy", cfg_busy, 1);
    @(negedge clock); #1;
    check("zero_busy_after", cfg_busy, 0);
    check("zero_done_after", job_done, 0);
    check("zero_no_start", start_cnt - s0, 0);
    check("zero_done_pulses", done_cnt - d0, 1);

    // Credit limit with the result stream blocked.
    @(posedge clock); #1;
    res_ready = 1'b0;
    a0 = acc_cnt;
    start_job(32'h200, 32'd20);
    repeat (40) @(negedge clock);
    #1;
    check("credit_calls", acc_cnt - a0, 8);
    check("credit_start_low", comp_start, 0);
    check("credit_valid", res_valid, 1);
    @(posedge clock); #1;
    res_ready = 1'b1;
    wait_idle("credit_idle", 300);
    check("credit_total_calls", acc_cnt - a0, 20);

    // Component busy pattern.
    a0 = acc_cnt;
    busy_mode = 1'b1;
    start_job(32'h1000, 32'd16);
    wait_idle("busy_idle", 400);
    busy_mode = 1'b0;
    check("busy_calls", acc_cnt - a0, 16);

    // Index wrap.
    wexp[0] = 32'hFFFF_FFFE; wexp[1] = 32'hFFFF_FFFF; wexp[2] = 32'h0;
    start_job(32'hFFFF_FFFE, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      check("wrap_idx", comp_idx, wexp[i]);
    end
    wait_idle("wrap_idle", 60);

    // cfg_start pulsed mid-job must be ignored.
    a0 = acc_cnt;
    start_job(32'd100, 32'd6);
    @(posedge clock); #1;
    cfg_start = 1'b1; cfg_base = 32'd500; cfg_count = 32'd2;
    @(posedge clock); #1;
    cfg_start = 1'b0;
    wait_idle("midjob_idle", 80);
    check("midjob_calls", acc_cnt - a0, 6);

    // Reset mid-job, then a stray return.
    a0 = acc_cnt;
    start_job(32'h3000, 32'd10);
    k = 0;
    while (acc_cnt - a0 < 5 && k < 50) begin
      @(negedge clock); #1;
      k++;
    end
    check("rst_mid_reached", (acc_cnt - a0 >= 5), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #1;
    check("rmid_busy", cfg_busy, 0);
    check("rmid_done", job_done, 0);
    check("rmid_start", comp_start, 0);
    check("rmid_stall", comp_stall, 0);
    check("rmid_valid", res_valid, 0);
    check("rmid_last", res_last, 0);
    check("rmid_err", err_unexpected, 0);
    check("rmid_idx", comp_idx, 0);
    check("rmid_data", res_data, 0);
    stray_cnt++;
    @(negedge clock); #1;
    @(negedge clock); #1;
    check("stray_err", err_unexpected, 1);
    check("stray_busy", cfg_busy, 0);
    check("stray_valid", res_valid, 0);
    check("stray_start", comp_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
